exhaustive_sweep_checker: RTL and testbench



---
 rtl/exhaustive_sweep_checker_if.sv | 25 ++
 rtl/exhaustive_sweep_checker.sv | 87 ++++++++
 tb/tb_exhaustive_sweep_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_sweep_checker_if.sv
// exhaustive_sweep_checker_if: control, stimulus and result signals between a sweep checker and its driver.
interface exhaustive_sweep_checker_if #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic [OUT_WIDTH-1:0] resp;
    logic [OUT_WIDTH-1:0] golden_sig;
    logic [WIDTH-1:0]     vec;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] signature;
    logic                 pass;

    modport master (
        output start, abort, resp, golden_sig,
        input  vec, busy, done, signature, pass
    );

    modport slave (
        input  start, abort, resp, golden_sig,
        output vec, busy, done, signature, pass
    );
endinterface

// File: rtl/exhaustive_sweep_checker.sv
// exhaustive_sweep_checker: sweeps every WIDTH-bit vector into a combinational block and
// compacts the responses into a MISR signature checked against a golden value.
module exhaustive_sweep_checker #(
    parameter int                   WIDTH     = 4,
    parameter int                   OUT_WIDTH = 4,
    parameter int                   DWELL     = 1,
    parameter logic [OUT_WIDTH-1:0] POLY      = OUT_WIDTH'(4'b0011)
) (
    input logic                       clk,
    input logic                       rst,
    exhaustive_sweep_checker_if.slave bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     vec_q;
    logic [OUT_WIDTH-1:0] sig_q;
    logic [OUT_WIDTH-1:0] sig_d;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sample;
    logic                 last;

    always_comb begin
        sig_d  = {sig_q[OUT_WIDTH-2:0], 1'b0} ^ (sig_q[OUT_WIDTH-1] ? POLY : '0) ^ bus.resp;
        sample = cnt_q == CW'(DWELL - 1);
        last   = &vec_q;
    end

    // The all-ones vector ends the sweep, so vec_q never needs an overflow bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        vec_q   <= '0;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (!sample) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        sig_q <= sig_d;
                        cnt_q <= '0;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q <= vec_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec       = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;
    assign bus.pass      = done_q && (sig_q == bus.golden_sig);
endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb_exhaustive_sweep_checker: table-driven sweeps on DWELL=1 and DWELL=3 instances with a
// per-cycle vector scoreboard, plus abort, golden-change and reset corner cases.
module tb_exhaustive_sweep_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic id1 = 1'b1;
    logic id3 = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exhaustive_sweep_checker_if #(.WIDTH(4), .OUT_WIDTH(4)) if1 ();
    exhaustive_sweep_checker_if #(.WIDTH(4), .OUT_WIDTH(4)) if3 ();

    exhaustive_sweep_checker #(.WIDTH(4), .OUT_WIDTH(4), .DWELL(1), .POLY(4'b0011)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    exhaustive_sweep_checker #(.WIDTH(4), .OUT_WIDTH(4), .DWELL(3), .POLY(4'b0011)) dut3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    assign if1.resp = id1 ? if1.vec : 4'h0;
    assign if3.resp = id3 ? if3.vec : 4'h0;

    logic [3:0] m_vec, m_sig;
    logic       m_busy, m_done, m_pass;
    assign m_vec  = sel ? if3.vec       : if1.vec;
    assign m_sig  = sel ? if3.signature : if1.signature;
    assign m_busy = sel ? if3.busy      : if1.busy;
    assign m_done = sel ? if3.done      : if1.done;
    assign m_pass = sel ? if3.pass      : if1.pass;

    typedef struct {
        bit         sel;
        bit         ident;
        logic [3:0] golden;
        logic [3:0] exp_sig;
        bit         exp_pass;
        int         mid_start;
    } row_t;

    row_t rows[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic v);
        if (sel) if3.start = v;
        else     if1.start = v;
    endtask

    task automatic drive_abort(input logic v);
        if (sel) if3.abort = v;
        else     if1.abort = v;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_busy"}, {31'b0, m_busy}, 0);
        chk({tag, "_done"}, {31'b0, m_done}, 0);
        chk({tag, "_vec"},  {28'b0, m_vec},  0);
        chk({tag, "_sig"},  {28'b0, m_sig},  0);
        chk({tag, "_pass"}, {31'b0, m_pass}, 0);
    endtask

    task automatic run_sweep(input row_t r);
        int         dw, cyc, busy_cnt;
        logic [3:0] q[$];
        sel = r.sel;
        dw  = r.sel ? 3 : 1;
        if (r.sel) begin id3 = r.ident; if3.golden_sig = r.golden; end
        else       begin id1 = r.ident; if1.golden_sig = r.golden; end
        q.delete();
        for (int v = 0; v < 16; v++)
            for (int d = 0; d < dw; d++) q.push_back(4'(v));
        drive_start(1'b1);
        tick();
        drive_start(1'b0);
        chk("start_busy", {31'b0, m_busy}, 1);
        chk("start_done", {31'b0, m_done}, 0);
        chk("start_vec",  {28'b0, m_vec},  0);
        chk("start_sig",  {28'b0, m_sig},  0);
        busy_cnt = 0;
        cyc = 0;
        while (!m_done && cyc < 200) begin
            if (m_busy) begin
                busy_cnt++;
                if (q.size() == 0) chk("vec_extra", 1, 0);
                else               chk("vec_step", {28'b0, m_vec}, {28'b0, q.pop_front()});
            end
            if (r.mid_start != 0 && cyc == r.mid_start) drive_start(1'b1);
            tick();
            drive_start(1'b0);
            cyc++;
        end
        chk("sweep_timeout", {31'b0, cyc < 200}, 1);
        chk("busy_cycles", busy_cnt, 16 * dw);
        chk("end_done", {31'b0, m_done}, 1);
        chk("end_busy", {31'b0, m_busy}, 0);
        chk("end_vec",  {28'b0, m_vec},  32'hF);
        chk("end_sig",  {28'b0, m_sig},  {28'b0, r.exp_sig});
        chk("end_pass", {31'b0, m_pass}, {31'b0, r.exp_pass});
        chk("vec_left", q.size(), 0);
    endtask

    initial begin
        rows[0] = '{sel: 1'b0, ident: 1'b1, golden: 4'hB, exp_sig: 4'hB, exp_pass: 1'b1, mid_start: 0};
        rows[1] = '{sel: 1'b0, ident: 1'b1, golden: 4'hB, exp_sig: 4'hB, exp_pass: 1'b1, mid_start: 5};
        rows[2] = '{sel: 1'b0, ident: 1'b0, golden: 4'hB, exp_sig: 4'h0, exp_pass: 1'b0, mid_start: 0};
        rows[3] = '{sel: 1'b1, ident: 1'b1, golden: 4'hB, exp_sig: 4'hB, exp_pass: 1'b1, mid_start: 0};
        rows[4] = '{sel: 1'b1, ident: 1'b1, golden: 4'hB, exp_sig: 4'hB, exp_pass: 1'b1, mid_start: 7};
        rows[5] = '{sel: 1'b1, ident: 1'b0, golden: 4'h0, exp_sig: 4'h0, exp_pass: 1'b1, mid_start: 0};
        if1.start = 1'b0; if1.abort = 1'b0; if1.golden_sig = 4'hB;
        if3.start = 1'b0; if3.abort = 1'b0; if3.golden_sig = 4'hB;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sel = 1'b0;
        check_idle_reset("reset1");
        sel = 1'b1;
        check_idle_reset("reset3");

        foreach (rows[i]) run_sweep(rows[i]);

        // Zero block against a wrong golden, then the golden changes while done is held.
        run_sweep(rows[2]);
        if1.golden_sig = 4'h0;
        #1;
        chk("golden_change_pass", {31'b0, m_pass}, 1);
        chk("golden_change_done", {31'b0, m_done}, 1);

        // Abort while done is ignored.
        drive_abort(1'b1);
        tick();
        drive_abort(1'b0);
        chk("abort_in_done", {31'b0, m_done}, 1);
        chk("abort_in_done_sig", {28'b0, m_sig}, 0);

        // Abort at vec=5 keeps partial vec and signature (0..4 compacted gives 2).
        sel = 1'b0;
        id1 = 1'b1;
        if1.golden_sig = 4'hB;
        drive_start(1'b1);
        tick();
        drive_start(1'b0);
        for (int n = 0; n < 40 && m_vec != 4'd5; n++) tick();
        chk("abort_reach5", {28'b0, m_vec}, 5);
        drive_abort(1'b1);
        tick();
        drive_abort(1'b0);
        chk("abort_busy", {31'b0, m_busy}, 0);
        chk("abort_done", {31'b0, m_done}, 0);
        chk("abort_vec",  {28'b0, m_vec},  5);
        chk("abort_sig",  {28'b0, m_sig},  2);
        tick();
        chk("abort_stay_vec", {28'b0, m_vec}, 5);
        run_sweep(rows[0]);

        // Reset mid-sweep with start held high must win and not begin a sweep.
        sel = 1'b1;
        drive_start(1'b1);
        tick();
        drive_start(1'b0);
        for (int n = 0; n < 6; n++) tick();
        chk("pre_rst_busy", {31'b0, m_busy}, 1);
        rst = 1'b1;
        drive_start(1'b1);
        tick();
        rst = 1'b0;
        drive_start(1'b0);
        check_idle_reset("midrst");
        tick();
        tick();
        chk("midrst_stay_busy", {31'b0, m_busy}, 0);
        chk("midrst_stay_vec", {28'b0, m_vec}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
